// File: rtl/sreg_pkg.sv
// Shared defaults, counter type and tap-clamp helper for the programmable delay line.
package sreg_pkg;

  localparam int SREG_WIDTH_DEF = 8;
  localparam int SREG_DEPTH_DEF = 4;

  // Shift counter for the default depth: one extra bit so it can hold DEPTH itself.
  typedef logic [$clog2(SREG_DEPTH_DEF):0] sreg_cnt_def_t;

  function automatic int clamp_sel(input int sel, input int depth);
    if (sel > depth - 1) begin
      return depth - 1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/sreg_stage.sv
// One delay-line stage: WIDTH data bits plus a valid bit, one cycle per enabled shift.
// Clear beats enable; with en low the stage simply holds.
module sreg_stage
  import sreg_pkg::*;
#(
  parameter int WIDTH = SREG_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH:0]   d,
  output logic [WIDTH:0]   q
);

  logic [WIDTH:0] q_q;
  logic [WIDTH:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sreg_delay_line.sv
// Programmable delay line: din reaches dout after sel_eff+1 enabled shifts; en low stalls the line.
// Optional SREG_TAPS_OUT_EN exposes every stage's data and valid bits.
module sreg_delay_line
  import sreg_pkg::*;
#(
  parameter int WIDTH = SREG_WIDTH_DEF,
  parameter int DEPTH = SREG_DEPTH_DEF,
  parameter int SELW  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    clr,
  input  logic [WIDTH-1:0]        din,
  input  logic                    din_vld,
  input  logic [SELW-1:0]         dly_sel,
  output logic [WIDTH-1:0]        dout,
  output logic                    dout_vld,
  output logic                    primed,
  output logic [SELW:0]           shift_cnt
`ifdef SREG_TAPS_OUT_EN
  ,
  output logic [DEPTH*WIDTH-1:0]  taps,
  output logic [DEPTH-1:0]        taps_vld
`endif
);

  // Each stage word is {valid, data}.
  logic [WIDTH:0] stage_q [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH:0] stage_d;
    if (k == 0) begin : g_head
      assign stage_d = {din_vld, din};
    end else begin : g_body
      assign stage_d = stage_q[k-1];
    end

    sreg_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .en    (en),
      .d     (stage_d),
      .q     (stage_q[k])
    );
  end

  logic [SELW:0] shift_cnt_q;
  logic [SELW:0] shift_cnt_d;

  always_comb begin
    shift_cnt_d = shift_cnt_q;
    if (clr) begin
      shift_cnt_d = '0;
    end else if (en && (shift_cnt_q != (SELW+1)'(DEPTH))) begin
      shift_cnt_d = shift_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_cnt_q <= '0;
    end else begin
      shift_cnt_q <= shift_cnt_d;
    end
  end

  // Tap select clamps so a non-power-of-2 DEPTH never indexes past the last stage.
  logic [SELW-1:0] sel_eff;
  assign sel_eff   = SELW'(clamp_sel(int'(dly_sel), DEPTH));

  assign dout      = stage_q[sel_eff][WIDTH-1:0];
  assign dout_vld  = stage_q[sel_eff][WIDTH];
  assign primed    = shift_cnt_q > {1'b0, sel_eff};
  assign shift_cnt = shift_cnt_q;

`ifdef SREG_TAPS_OUT_EN
  for (genvar k = 0; k < DEPTH; k++) begin : g_taps
    assign taps[k*WIDTH +: WIDTH] = stage_q[k][WIDTH-1:0];
    assign taps_vld[k]            = stage_q[k][WIDTH];
  end
`else
  // Stage contents stay internal; only the selected tap is visible.
`endif

endmodule

// File: tb/tb_sreg_delay_line.sv
// Directed bench for sreg_delay_line at default parameters (8-bit, 4 stages).
module tb_sreg_delay_line;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       clr;
  logic [7:0] din;
  logic       din_vld;
  logic [1:0] dly_sel;
  logic [7:0] dout;
  logic       dout_vld;
  logic       primed;
  logic [2:0] shift_cnt;
`ifdef SREG_TAPS_OUT_EN
  logic [31:0] taps;
  logic [3:0]  taps_vld;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sreg_delay_line dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .clr       (clr),
    .din       (din),
    .din_vld   (din_vld),
    .dly_sel   (dly_sel),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .primed    (primed),
    .shift_cnt (shift_cnt)
`ifdef SREG_TAPS_OUT_EN
    ,
    .taps      (taps),
    .taps_vld  (taps_vld)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic v,
                         input logic p, input logic [2:0] c);
    chk({tag, ".dout"},      dout,      d);
    chk({tag, ".dout_vld"},  dout_vld,  v);
    chk({tag, ".primed"},    primed,    p);
    chk({tag, ".shift_cnt"}, shift_cnt, c);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; en = 1'b0; clr = 1'b0; din = 8'h00; din_vld = 1'b0; dly_sel = 2'd3;
    #12;
    chk_out("reset", 8'h00, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    reset = 1'b1;

    // 1: fill with 0x11..0x88 at dly_sel=3
    en = 1'b1; din_vld = 1'b1;
    din = 8'h11; step(); chk_out("s1.e1", 8'h00, 1'b0, 1'b0, 3'd1);
    din = 8'h22; step(); chk_out("s1.e2", 8'h00, 1'b0, 1'b0, 3'd2);
    din = 8'h33; step(); chk_out("s1.e3", 8'h00, 1'b0, 1'b0, 3'd3);
    din = 8'h44; step(); chk_out("s1.e4", 8'h11, 1'b1, 1'b1, 3'd4);
    din = 8'h55; step(); chk_out("s1.e5", 8'h22, 1'b1, 1'b1, 3'd4);
    din = 8'h66; step(); chk_out("s1.e6", 8'h33, 1'b1, 1'b1, 3'd4);
    din = 8'h77; step(); chk_out("s1.e7", 8'h44, 1'b1, 1'b1, 3'd4);
    din = 8'h88; step(); chk_out("s1.e8", 8'h55, 1'b1, 1'b1, 3'd4);

    // 2: dly_sel=0 after a clear, one-edge latency
    clr = 1'b1; step(); clr = 1'b0;
    dly_sel = 2'd0; #1;
    chk_out("s2.pre", 8'h00, 1'b0, 1'b0, 3'd0);
    din = 8'hA5; step();
    chk_out("s2.e1", 8'hA5, 1'b1, 1'b1, 3'd1);

    // 3: en pattern 1,0,0,1,1,1 at dly_sel=3
    clr = 1'b1; step(); clr = 1'b0;
    dly_sel = 2'd3;
    en = 1'b1; din = 8'h01; step(); chk_out("s3.c1", 8'h00, 1'b0, 1'b0, 3'd1);
    en = 1'b0; din = 8'hEE; step(); chk_out("s3.c2", 8'h00, 1'b0, 1'b0, 3'd1);
    step();                       chk_out("s3.c3", 8'h00, 1'b0, 1'b0, 3'd1);
    dly_sel = 2'd0; #1;
    chk("s3.frozen_d0", dout, 8'h01);
    dly_sel = 2'd3;
    en = 1'b1; din = 8'h02; step(); chk_out("s3.c4", 8'h00, 1'b0, 1'b0, 3'd2);
    din = 8'h03;            step(); chk_out("s3.c5", 8'h00, 1'b0, 1'b0, 3'd3);
    din = 8'h04;            step(); chk_out("s3.c6", 8'h01, 1'b1, 1'b1, 3'd4);

    // 4: clear wins over enable; din presented during clear is dropped
    clr = 1'b1; en = 1'b1; din = 8'h99; step();
    clr = 1'b0; en = 1'b0;
    chk_out("s4.clr", 8'h00, 1'b0, 1'b0, 3'd0);
    dly_sel = 2'd0; #1;
    chk("s4.d0_dout", dout, 8'h00);
    chk("s4.d0_vld", dout_vld, 1'b0);
    dly_sel = 2'd3;

    // 5: asynchronous reset mid-cycle, then refill
    en = 1'b1;
    din = 8'h11; step();
    din = 8'h22; step();
    din = 8'h33; step();
    din = 8'h44; step();
    chk_out("s5.full", 8'h11, 1'b1, 1'b1, 3'd4);
    #1 reset = 1'b0;
    #1;
    chk_out("s5.async", 8'h00, 1'b0, 1'b0, 3'd0);
    #1 reset = 1'b1;
    din = 8'h11; step();
    din = 8'h22; step();
    din = 8'h33; step(); chk_out("s5.r3", 8'h00, 1'b0, 1'b0, 3'd3);
    din = 8'h44; step(); chk_out("s5.r4", 8'h11, 1'b1, 1'b1, 3'd4);

    // 6: running stream with an invalid word, tap switched 3->1->3
    din = 8'h10; din_vld = 1'b1; step();
    din = 8'h20; din_vld = 1'b1; step();
    din = 8'h30; din_vld = 1'b0; step();
    din = 8'h40; din_vld = 1'b1; step();
    chk_out("s6.t3a", 8'h10, 1'b1, 1'b1, 3'd4);
    dly_sel = 2'd1; #1;
    chk_out("s6.t1a", 8'h30, 1'b0, 1'b1, 3'd4);
    din = 8'h50; step();
    chk_out("s6.t1b", 8'h40, 1'b1, 1'b1, 3'd4);
    dly_sel = 2'd3; #1;
    chk_out("s6.t3b", 8'h20, 1'b1, 1'b1, 3'd4);
    din = 8'h60; step(); chk_out("s6.t3c", 8'h30, 1'b0, 1'b1, 3'd4);
    din = 8'h70; step(); chk_out("s6.t3d", 8'h40, 1'b1, 1'b1, 3'd4);
    din = 8'h80; step(); chk_out("s6.t3e", 8'h50, 1'b1, 1'b1, 3'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sreg_delay_line.md
Name: sreg_delay_line

Overview:
Parametrised programmable delay line. It is the generalised successor of the fixed 8-bit, 4-stage shift register.
- Configurable data width and depth.
- Per-stage valid tracking.
- Shift enable and synchronous clear.
- Run-time selectable output tap.
- Used wherever a datapath needs a variable alignment delay. Default parameters reproduce the legacy 8-bit/4-cycle behaviour with dly_sel=3.

Parameters:
WIDTH, 8, data bits per stage
DEPTH, 4, number of storage stages (>=2)
SELW, $clog2(DEPTH), width of dly_sel

Ports:
clk  in  1  clock, rising-edge active
reset  in  1  asynchronous, active-low reset
en  in  1  shift enable; stages advance only when high
clr  in  1  synchronous clear of all stages, valids and counter
din  in  WIDTH  data into stage 0
din_vld  in  1  valid qualifier shifted alongside din
dly_sel  in  SELW  output tap index; delay = dly_sel+1 enabled cycles
dout  out  WIDTH  data at selected tap
dout_vld  out  1  valid bit at selected tap
primed  out  1  high once enough shifts since reset/clr fill the selected tap
shift_cnt  out  SELW+1  enabled-shift counter, saturating at DEPTH

Behaviour:
- Storage: data D[0..DEPTH-1] and valid V[0..DEPTH-1].
- Reset (reset=0, asynchronous, immediate even mid-operation): all D=0, all V=0, shift_cnt=0. Hence dout=0, dout_vld=0 and primed=0 while reset is asserted.
- Clock edge, priority clr > en:
  - clr=1: all D=0, V=0, shift_cnt=0, regardless of en.
  - en=1: D[0]<=din, V[0]<=din_vld, D[k]<=D[k-1], V[k]<=V[k-1] for k=1..DEPTH-1; shift_cnt<=min(shift_cnt+1, DEPTH).
  - en=0: all state holds, including shift_cnt.
- Effective tap: sel_eff = min(dly_sel, DEPTH-1). Out-of-range dly_sel (non-power-of-2 DEPTH) clamps to the last stage.
- dout=D[sel_eff] and dout_vld=V[sel_eff]; this is a combinational mux, not an extra register. Latency from din to dout is sel_eff+1 enabled clock edges.
- primed = (shift_cnt > sel_eff), combinational.
- Changing dly_sel mid-stream takes effect in the same cycle. Data already in the line is not dropped or duplicated; the output simply switches tap. primed re-evaluates against the new tap.
- en toggling: a gap cycle (en=0) stretches the latency in clock cycles but not in enabled shifts.
- Data is not gated by din_vld. Invalid words still shift, and their V bit marks them.
- No combinational path from din to dout.

Optional Feature:
SREG_TAPS_OUT_EN
- Defined: adds output port taps of width DEPTH*WIDTH, with taps[k*WIDTH +: WIDTH]=D[k], plus taps_vld of width DEPTH (=V). Both have the same reset and clear behaviour as the stages.
- Undefined: neither port exists. Core behaviour is identical.

Decomposition:
- Shared package sreg_pkg:
  - default WIDTH/DEPTH constants.
  - function clamp_sel(dly_sel, DEPTH).
  - typedef for the saturating counter width.
- One sub-module, sreg_stage: a single WIDTH+1-bit register with async active-low reset, sync clear and enable. It is instantiated DEPTH times in a generate loop. The mux, counter and primed logic stay in the top module.

Test Plan:
1. Defaults, dly_sel=3, en=1, din=0x11,0x22,0x33,0x44,0x55 on successive edges, din_vld=1 -> dout=0x11 after the 4th edge, 0x55 after the 8th; primed rises after the 4th edge; shift_cnt saturates at 4.
2. dly_sel=0, din=0xA5 -> dout=0xA5 and dout_vld=1 after 1 edge; primed after 1 edge.
3. en pattern 1,0,0,1,1,1 with dly_sel=3, din=0x01 first -> dout=0x01 only after the 4th enabled edge (6th clock); state frozen during en=0.
4. Line full (dly_sel=3), assert clr and en together for one edge -> all stages, dout, dout_vld, shift_cnt and primed = 0 next cycle; the din presented during clr is discarded.
5. Assert reset=0 asynchronously mid-cycle with nonzero data -> dout=0, dout_vld=0, primed=0 before the next clock edge; after release, refill matches scenario 1.
6. Running stream 0x10,0x20,...: switch dly_sel 3->1 -> dout immediately shows D[1]; primed stays 1 (shift_cnt=4>1). Switch back to 3 -> dout shows D[3] with no lost valid words.
